simd_regfile: RTL
=================

# simd_regfile

Per-thread SIMD register file and the responder end of the lane's register-file interface. It serves each lane's two combinational operand reads in ID (AD1/AD2 for thread tIdx) and accepts the lane's WB write (AD3/WD3/WE3 for a write thread). One instance sits beside each lane. A post-reset clear sequencer zeroes all storage and holds the lane stalled until the storage is known-clean.

## Interface
- NUM_THREADS, 16: threads per lane; tIdx width is clog2(NUM_THREADS)=4
- NUM_REGS, 32: architectural registers per thread; address width 5
- DATA_W, 32: register width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- AD1  in  5  read port 1 register address
- AD2  in  5  read port 2 register address
- tIdx  in  4  thread selected for both reads
- RD1  out  32  read data port 1, combinational
- RD2  out  32  read data port 2, combinational
- AD3  in  5  write register address
- WD3  in  32  write data
- WE3  in  1  write enable
- tIdx_wr  in  4  thread selected for the write
- stall_out  out  1  high while clearing; the lane must not issue or retire

## Operation
- Storage: NUM_THREADS × NUM_REGS words of DATA_W, indexed {thread, reg}.
- Register 0 of every thread reads as 0. Writes to AD3=0 are discarded.
- Read: RD1 = mem[tIdx][AD1] and RD2 = mem[tIdx][AD2] (asynchronous), subject to x0 and bypass rules.
- Write: when WE3=1, state=READY, and AD3≠0, mem[tIdx_wr][AD3] <= WD3 at the clock edge.
- Clear FSM, states CLEAR and READY:
  - rst=1: state <= CLEAR, clr_ptr <= 0.
  - CLEAR: each cycle writes 0 to entry clr_ptr (flat index 0..511) and increments clr_ptr. When clr_ptr = NUM_THREADS*NUM_REGS-1 is written, state <= READY.
  - READY: normal operation. No return to CLEAR except via rst.
- While in CLEAR: stall_out=1, RD1=RD2=0, WE3 is ignored (not queued).
- Reset mid-clear restarts clr_ptr at 0.

## Timing
- Reset values: state=CLEAR, clr_ptr=0, stall_out=1, RD1=RD2=0.
- Clear duration: 512 cycles after rst deasserts (NUM_THREADS*NUM_REGS). stall_out falls in the cycle after the final clear write.
- Read latency: 0 cycles, combinational from AD1/AD2/tIdx.
- Write latency: visible in the array on the cycle after the edge where WE3=1.
- Same-cycle read and write of the same {thread, reg}: behaviour depends on REGFILE_BYPASS_EN (see Configuration).
- Write address bits beyond NUM_REGS or NUM_THREADS: not applicable at the default power-of-two sizes. For non-power-of-two sizes, out-of-range writes are dropped and out-of-range reads return 0.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Write-to-read forwarding. If WE3=1, state=READY, AD3≠0, tIdx_wr=tIdx, and AD3 equals AD1 (or AD2), then RD1 (or RD2) = WD3 in the same cycle.
  - This removes the lane's WB→ID hazard.
- REGFILE_BYPASS_EN undefined:
  - Reads always return array contents, so a same-cycle write is seen one cycle later.
  - The lane must stall for that hazard.

## Structure
- Shared package simd_pkg holds:
  - NUM_THREADS, NUM_REGS, DATA_W constants
  - typedefs reg_addr_t (logic [4:0]), thread_idx_t (logic [3:0]), word_t (logic [31:0])
  - rf_state_e enum {CLEAR, READY}
- One sub-module, simd_rf_clear_seq: contains the FSM and clr_ptr, and outputs clr_we, clr_addr, and busy (busy drives stall_out).
- The top level muxes the clear write against the WB write and implements the x0 and bypass logic.

## Test plan
- Reset, then hold rst low: stall_out=1 for exactly 512 cycles, then 0. Every {t,r} read after clear returns 0.
- Write WD3=0xDEADBEEF to tIdx_wr=3, AD3=7; next cycle read tIdx=3, AD1=7 → RD1=0xDEADBEEF. Read tIdx=4, AD1=7 → RD1=0 (thread isolation).
- Write 0x12345678 to AD3=0 on thread 5 → reads of tIdx=5, AD1=0 and AD2=0 return 0.
- Same cycle: write 0xA5A5A5A5 to t2/r9 while reading t2, AD2=9. With REGFILE_BYPASS_EN, RD2=0xA5A5A5A5. Without it, RD2 returns the old value and shows 0xA5A5A5A5 the next cycle.
- Pulse WE3 (t1/r1=0xFF) at clear cycle 100 → ignored. After clear completes, t1/r1 reads 0.
- Assert rst for 1 cycle at clear cycle 300 → stall_out stays 1 for a further full 512 cycles after the release.

Source files
------------

// File: rtl/simd_pkg.sv
// simd_pkg: shared sizes, types and clear-FSM states
// for the per-lane SIMD register file.
package simd_pkg;

  localparam int NUM_THREADS = 16;
  localparam int NUM_REGS    = 32;
  localparam int DATA_W      = 32;

  localparam int TID_W = $clog2(NUM_THREADS);
  localparam int REG_W = $clog2(NUM_REGS);
  localparam int DEPTH = NUM_THREADS * NUM_REGS;
  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [REG_W-1:0]  reg_addr_t;
  typedef logic [TID_W-1:0]  thread_idx_t;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [PTR_W-1:0]  flat_idx_t;

  typedef enum logic {
    CLEAR,
    READY
  } rf_state_e;

endpackage

// File: rtl/simd_regfile_if.sv
// simd_regfile_if: lane <-> register-file port bundle.
// master = lane (ID reads, WB write), slave = regfile.
interface simd_regfile_if;
  import simd_pkg::*;

  reg_addr_t   AD1;
  reg_addr_t   AD2;
  thread_idx_t tIdx;
  word_t       RD1;
  word_t       RD2;
  reg_addr_t   AD3;
  word_t       WD3;
  logic        WE3;
  thread_idx_t tIdx_wr;
  logic        stall_out;

  modport master (
    output AD1, AD2, tIdx,
    output AD3, WD3, WE3, tIdx_wr,
    input  RD1, RD2, stall_out
  );

  modport slave (
    input  AD1, AD2, tIdx,
    input  AD3, WD3, WE3, tIdx_wr,
    output RD1, RD2, stall_out
  );

endinterface

// File: rtl/simd_rf_clear_seq.sv
// simd_rf_clear_seq: post-reset sweep that zeroes
// every register-file entry, one per cycle.
module simd_rf_clear_seq
  import simd_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  output logic      clr_we,
  output flat_idx_t clr_addr,
  output logic      busy
);

  localparam flat_idx_t LAST = flat_idx_t'(DEPTH - 1);

  rf_state_e state_q, state_d;
  flat_idx_t ptr_q, ptr_d;

  // state and sweep pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // advance the sweep; leave CLEAR once the last entry is written
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST) begin
          state_d = READY;
          ptr_d   = '0;
        end
      end
      READY: ;
      default: ;
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = ptr_q;

endmodule

// File: rtl/simd_regfile.sv
// simd_regfile: per-thread SIMD register file, two async reads, one write.
// Define REGFILE_BYPASS_EN for same-cycle WB->ID forwarding.
module simd_regfile
  import simd_pkg::*;
(
  input logic           clk,
  input logic           rst,
  simd_regfile_if.slave rf
);

  word_t mem [NUM_THREADS][NUM_REGS];

  logic        clr_we;
  logic        busy;
  flat_idx_t   clr_addr;
  thread_idx_t clr_thr;
  reg_addr_t   clr_reg;

  logic        wr_en;
  thread_idx_t wr_thr;
  reg_addr_t   wr_reg;
  word_t       wr_data;
  word_t       rd1;
  word_t       rd2;

  simd_rf_clear_seq u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (busy)
  );

  assign clr_thr = clr_addr[PTR_W-1 -: TID_W];
  assign clr_reg = clr_addr[REG_W-1:0];

  // clear sweep owns the port while busy; WB writes to x0 are dropped
  always_comb begin
    wr_en   = 1'b0;
    wr_thr  = rf.tIdx_wr;
    wr_reg  = rf.AD3;
    wr_data = rf.WD3;
    if (clr_we) begin
      wr_en   = 1'b1;
      wr_thr  = clr_thr;
      wr_reg  = clr_reg;
      wr_data = '0;
    end else if (rf.WE3 && rf.AD3 != '0) begin
      wr_en = 1'b1;
    end
  end

  // storage write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_thr][wr_reg] <= wr_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic wb_hit;
  assign wb_hit = rf.WE3 && !busy && rf.AD3 != '0 &&
                  rf.tIdx_wr == rf.tIdx;
`endif

  // operand reads with optional forwarding, x0 and clear masking
  always_comb begin
    rd1 = mem[rf.tIdx][rf.AD1];
    rd2 = mem[rf.tIdx][rf.AD2];
`ifdef REGFILE_BYPASS_EN
    if (wb_hit && rf.AD3 == rf.AD1) rd1 = rf.WD3;
    if (wb_hit && rf.AD3 == rf.AD2) rd2 = rf.WD3;
`endif
    if (busy || rf.AD1 == '0) rd1 = '0;
    if (busy || rf.AD2 == '0) rd2 = '0;
  end

  assign rf.RD1       = rd1;
  assign rf.RD2       = rd2;
  assign rf.stall_out = busy;

endmodule
